// File: rtl/qar_dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// bus width and the address-fault helpers.
package qar_dmem_responder_pkg;

  localparam int BUS_W   = 32;
  localparam int ALIGN_W = 2;
  localparam int IDX_W   = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  function automatic logic [IDX_W-1:0] word_index(input logic [BUS_W-1:0] addr,
                                                  input logic [BUS_W-1:0] base);
    logic [BUS_W-1:0] diff;
    diff = addr - base;
    return IDX_W'(diff >> ALIGN_W);
  endfunction

  // Index is checked at full width so out-of-range addresses never alias.
  function automatic logic addr_fault(input logic [BUS_W-1:0] addr,
                                      input logic [BUS_W-1:0] base,
                                      input logic [IDX_W-1:0] idx,
                                      input logic [IDX_W-1:0] depth);
    return (addr[ALIGN_W-1:0] != '0) || (addr < base) || (idx >= depth);
  endfunction

endpackage

// File: rtl/qar_word_ram.sv
// Single-clock word RAM: registered read, bus and init write ports,
// bus port wins when both target the same word.
module qar_word_ram #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_W-1:0]     bus_wdata,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_W-1:0]     init_wdata,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Bus write is issued last so it overrides init on a same-word collision.
  always_ff @(posedge clk) begin
    if (init_we) mem_q[init_addr] <= init_wdata;
    if (bus_we)  mem_q[bus_addr]  <= bus_wdata;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/qar_dmem_responder.sv
// Data-memory responder: latches one core request, optionally inserts wait
// states, then answers with a single-cycle ready pulse.
import qar_dmem_responder_pkg::*;

module qar_dmem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  mem_err,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [31:0]           init_wdata
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [BUS_W-1:0]       wdata_q, wdata_d;
  logic [IDX_W-1:0]       in_idx;
  logic                   in_fault;
  logic                   ram_we;
  logic [BUS_W-1:0]       ram_rdata;

  assign in_idx   = word_index(mem_addr, BASE_ADDR);
  assign in_fault = addr_fault(mem_addr, BASE_ADDR, in_idx, IDX_W'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Fault status is resolved at acceptance; the address never changes afterwards.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          we_d    = mem_we;
          err_d   = in_fault;
          idx_d   = in_idx[ADDR_WIDTH-1:0];
          wdata_d = mem_wdata;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state_q == ST_RESP);
    mem_err   = mem_ready && err_q;
    mem_rdata = (mem_ready && !err_q && !we_q) ? ram_rdata : '0;
    ram_we    = mem_ready && we_q && !err_q;
  end

  // Read address follows the next-cycle index so data is registered on RESP entry.
  qar_word_ram #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_W    (BUS_W)
  ) u_ram (
    .clk       (clk),
    .bus_we    (ram_we),
    .bus_addr  (idx_q),
    .bus_wdata (wdata_q),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_wdata(init_wdata),
    .rd_addr   (idx_d),
    .rd_data   (ram_rdata)
  );

endmodule

// File: tb/tb_qar_dmem_responder.sv
// Directed bench: DUT 0 runs with no wait states, DUT 1 with three.
module tb_qar_dmem_responder;

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       mem_valid, mem_we, mem_ready, mem_err, init_we;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata, init_wdata;
  logic [1:0][7:0]  init_addr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qar_dmem_responder #(.DEPTH(256), .ADDR_WIDTH(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .mem_valid(mem_valid[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_ready(mem_ready[0]),
    .mem_rdata(mem_rdata[0]), .mem_err(mem_err[0]), .init_we(init_we[0]),
    .init_addr(init_addr[0]), .init_wdata(init_wdata[0]));

  qar_dmem_responder #(.DEPTH(256), .ADDR_WIDTH(8), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .mem_valid(mem_valid[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_ready(mem_ready[1]),
    .mem_rdata(mem_rdata[1]), .mem_err(mem_err[1]), .init_we(init_we[1]),
    .init_addr(init_addr[1]), .init_wdata(init_wdata[1]));

  task automatic preload(input int d, input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    init_we[d] = 1'b1; init_addr[d] = idx; init_wdata[d] = data;
    @(negedge clk);
    init_we[d] = 1'b0;
  endtask

  // One complete access; optionally fires an init write during the RESP cycle.
  task automatic bus_access(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int exp_lat,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic hold, input logic do_init,
                            input logic [7:0] iaddr, input logic [31:0] idata,
                            input string name);
    int lat;
    @(negedge clk);
    mem_valid[d] = 1'b1; mem_we[d] = we; mem_addr[d] = addr; mem_wdata[d] = wdata;
    @(posedge clk); #1;
    if (!hold) mem_valid[d] = 1'b0;
    lat = 1;
    while (mem_ready[d] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (mem_rdata[d] !== exp_rdata) begin
      errors++; $display("FAIL %s rdata: got %h want %h", name, mem_rdata[d], exp_rdata);
    end
    checks++;
    if (mem_err[d] !== exp_err) begin
      errors++; $display("FAIL %s err: got %b want %b", name, mem_err[d], exp_err);
    end
    if (do_init) begin
      init_we[d] = 1'b1; init_addr[d] = iaddr; init_wdata[d] = idata;
    end
    mem_valid[d] = 1'b0;
    @(posedge clk); #1;
    init_we[d] = 1'b0;
    checks++;
    if (mem_ready[d] !== 1'b0 || mem_rdata[d] !== 32'h0 || mem_err[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s after_resp: got ready=%b rdata=%h err=%b want 0/0/0",
               name, mem_ready[d], mem_rdata[d], mem_err[d]);
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    mem_valid = '0; mem_we = '0; mem_addr = '0; mem_wdata = '0;
    init_we = '0; init_addr = '0; init_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mem_ready[d] !== 1'b0 || mem_rdata[d] !== 32'h0 || mem_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got ready=%b rdata=%h err=%b want 0/0/0",
                 d, mem_ready[d], mem_rdata[d], mem_err[d]);
      end
    end
    @(negedge clk);
    rst = 2'b00;
  endtask

  task automatic test_read_nowait();
    preload(0, 8'd5, 32'hDEADBEEF);
    bus_access(0, 1'b0, 32'h14, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "read_nowait");
  endtask

  task automatic test_write_read_wait();
    bus_access(1, 1'b1, 32'h20, 32'h12345678, 4, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "write_wait");
    bus_access(1, 1'b0, 32'h20, 32'h0, 4, 32'h12345678, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "read_wait");
  endtask

  task automatic test_faults();
    preload(1, 8'd8, 32'h0F0F0F0F);
    preload(1, 8'd0, 32'hCAFE0000);
    bus_access(1, 1'b0, 32'h22, 32'h0, 4, 32'h0, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, "misaligned_read");
    bus_access(1, 1'b1, 32'h400, 32'hFFFFFFFF, 4, 32'h0, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, "oob_write");
    bus_access(1, 1'b0, 32'h0, 32'h0, 4, 32'hCAFE0000, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "word0_intact");
    bus_access(1, 1'b0, 32'h400, 32'h0, 4, 32'h0, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, "oob_read");
    bus_access(1, 1'b1, 32'h3FC, 32'h13579BDF, 4, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "last_write");
    bus_access(1, 1'b0, 32'h3FC, 32'h0, 4, 32'h13579BDF, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "last_read");
  endtask

  task automatic test_conflict();
    bus_access(1, 1'b1, 32'h20, 32'h55555555, 4, 32'h0, 1'b0, 1'b1, 1'b1, 8'd8, 32'hAAAAAAAA, "conflict_write");
    bus_access(1, 1'b0, 32'h20, 32'h0, 4, 32'h55555555, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "conflict_read");
    bus_access(1, 1'b0, 32'h24, 32'h0, 4, 32'h0, 1'b0, 1'b1, 1'b1, 8'd9, 32'h77777777, "init_during_read");
    bus_access(1, 1'b0, 32'h24, 32'h0, 4, 32'h77777777, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "init_read_back");
  endtask

  task automatic test_back_to_back();
    bus_access(0, 1'b1, 32'h18, 32'h00000001, 1, 32'h0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, "b2b_write");
    bus_access(0, 1'b0, 32'h18, 32'h0, 1, 32'h00000001, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, "b2b_read");
    bus_access(1, 1'b0, 32'h14, 32'h0, 4, 32'h0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, "drop_valid_wait");
  endtask

  task automatic test_reset_mid();
    int seen;
    preload(1, 8'd12, 32'h0BADF00D);
    @(negedge clk);
    mem_valid[1] = 1'b1; mem_we[1] = 1'b1; mem_addr[1] = 32'h30; mem_wdata[1] = 32'h1;
    @(posedge clk); #1;
    mem_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_ready[1] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid ready: got %0d pulses want 0", seen);
    end
    @(negedge clk);
    rst[1] = 1'b0;
    bus_access(1, 1'b0, 32'h30, 32'h0, 4, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0, "reset_mid_read");
  endtask

  initial begin
    test_reset();
    test_read_nowait();
    test_write_read_wait();
    test_faults();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qar_dmem_responder.md
QAR_DMEM_RESPONDER -- requirements
Module: qar_dmem_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 256, number of 32-bit words
- ADDR_WIDTH, 8, word-index width (log2 DEPTH)
- WAIT_CYCLES, 0, extra wait states per access (0..15)
- BASE_ADDR, 32'h0000_0000, byte address of word 0
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous active-high reset
- mem_valid, in, 1, core request valid, held until mem_ready
- mem_we, in, 1, 1=write, 0=read
- mem_addr, in, 32, byte address
- mem_wdata, in, 32, write data
- mem_ready, out, 1, one-cycle completion pulse
- mem_rdata, out, 32, read data, valid while mem_ready=1
- mem_err, out, 1, access fault, valid while mem_ready=1
- init_we, in, 1, backdoor preload strobe
- init_addr, in, ADDR_WIDTH, backdoor word index
- init_wdata, in, 32, backdoor data
REQ-003 The block SHALL use one clock, clk, with asynchronous active-high reset, rst.

Function
REQ-004 FSM states SHALL be IDLE, WAIT, RESP.
REQ-005 In IDLE, mem_valid=1 at a rising edge SHALL latch mem_we, mem_addr and mem_wdata, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-006 WAIT SHALL count down WAIT_CYCLES cycles using a 4-bit counter, then go to RESP.
REQ-007 RESP SHALL last exactly one cycle, drive mem_ready=1, then return to IDLE; RESP SHALL NOT accept a new request.
REQ-008 mem_ready SHALL assert WAIT_CYCLES+1 cycles after the acceptance edge; minimum spacing between accesses is two cycles.
REQ-009 Word index SHALL be (addr-BASE_ADDR)>>2, computed in 32-bit unsigned arithmetic.
REQ-010 Fault: mem_err=1 in RESP when addr[1:0]!=0, addr<BASE_ADDR, or index>=DEPTH. A faulted write SHALL NOT modify memory; a faulted read SHALL return mem_rdata=0.
REQ-011 A legal write SHALL commit on the RESP cycle's closing edge.
REQ-012 A legal read SHALL return the word as stored at RESP entry, including a same-address init write from earlier.
REQ-013 Outside RESP, mem_rdata SHALL be 0 and mem_err SHALL be 0.
REQ-014 init_we=1 SHALL write init_wdata to init_addr in any state. On the same edge as a committing bus write to the same word, the bus write SHALL win.
REQ-015 Request fields SHALL be used from the latch only; mem_valid deasserting during WAIT SHALL NOT abort the access.
REQ-016 The address space SHALL NOT wrap: an index at or above DEPTH SHALL fault, never alias.

Reset
REQ-017 rst=1 SHALL immediately force IDLE, counter=0, mem_ready=0, mem_rdata=0, mem_err=0 and clear the latched request.
REQ-018 Reset SHALL NOT clear memory contents. A write pending in WAIT or RESP when rst asserts SHALL be dropped.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, the bus width constant (32) and the fault-check width constants.
REQ-020 Storage SHALL be one sub-module, qar_word_ram: a single-clock RAM with a registered read port and two write ports (bus and init) with fixed priority.
REQ-021 The RTL SHALL be synthesizable, with no initial blocks and no $readmemh; the testbench preloads memory through init_*.

Verification
REQ-022 WAIT_CYCLES=0: init word 5=32'hDEADBEEF; read addr 0x14 -> mem_ready pulses one cycle later, mem_rdata=32'hDEADBEEF, mem_err=0.
REQ-023 WAIT_CYCLES=3: write 0x12345678 to 0x20, then read 0x20 -> each mem_ready arrives 4 cycles after acceptance, read returns 0x12345678.
REQ-024 Faults: read 0x22 -> mem_err=1, mem_rdata=0. Write to 0x400 with DEPTH=256 -> mem_err=1, word 0 unchanged.
REQ-025 Same-edge conflict: init_we to word 8 (0xAAAAAAAA) on the bus-write commit edge for 0x20 (0x55555555) -> a later read returns 0x55555555.
REQ-026 Reset mid-access: with WAIT_CYCLES=3, assert rst during WAIT of a write 0x1 to 0x30 -> mem_ready never pulses, word 12 keeps its old value, and the next read works normally.
